// File: rtl/nibble_mac_sequencer.sv
// nibble_mac_sequencer
// Sequences one inference pass for a nibble-loaded weight/data datapath.
// Four signed int8 weights and four vectors of four signed int8 data bytes are
// shifted in one nibble at a time, MSB-first. A START command then runs one
// shared 8x8 MAC for 16 steps. The block emits one ReLU-clipped, saturated
// result byte per vector.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   nib_i        load nibble, or command code when sel_i = 2'b11
//   sel_i        2'b00 none, 2'b01 weight nibble, 2'b10 data nibble, 2'b11 command
//   strobe_i     qualifies nib_i/sel_i for this cycle only
//   out_byte_o   result byte; holds its value between pulses
//   out_valid_o  one-cycle pulse while out_byte_o carries a new result
//   busy_o       high while a pass is computing
//   done_o       one-cycle pulse at the end of a pass
//   err_o        sticky error flag; cleared by CLEAR or by reset
module nibble_mac_sequencer #(
  parameter int WEIGHT_W = 32,
  parameter int DATA_W   = 128,
  parameter int ACC_W    = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] nib_i,
  input  logic [1:0] sel_i,
  input  logic       strobe_i,
  output logic [7:0] out_byte_o,
  output logic       out_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int W_NIBS = WEIGHT_W / 4;
  localparam int D_NIBS = DATA_W / 4;
  localparam int WC_W   = $clog2(W_NIBS + 1);
  localparam int DC_W   = $clog2(D_NIBS + 1);

  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_CLEAR = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_LAST  = 2'd2,  // the last step is done; the final result is pending
    S_DRAIN = 2'd3   // busy has already dropped; state returns to IDLE next
  } state_t;

  state_t                   state_q;
  logic [WEIGHT_W-1:0]      w_q;
  logic [DATA_W-1:0]        d_q;
  logic [WC_W-1:0]          w_cnt_q;
  logic [DC_W-1:0]          d_cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [3:0]               step_q;
  logic                     pend_q;  // an acc total is ready to emit next cycle
  logic [7:0]               out_byte_q;
  logic                     out_valid_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;

  logic                     cmd_start_s;
  logic                     cmd_clear_s;
  logic                     load_w_s;
  logic                     load_d_s;
  logic                     full_s;
  logic [7:0]               w_byte_s;
  logic [7:0]               d_byte_s;
  logic signed [15:0]       prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  acc_d;
  logic [7:0]               relu_s;

  // Decode the strobe into load and command requests.
  always_comb begin
    load_w_s    = strobe_i && (sel_i == 2'b01);
    load_d_s    = strobe_i && (sel_i == 2'b10);
    cmd_start_s = strobe_i && (sel_i == 2'b11) && (nib_i == CMD_START);
    cmd_clear_s = strobe_i && (sel_i == 2'b11) && (nib_i == CMD_CLEAR);
    full_s      = (w_cnt_q == WC_W'(W_NIBS)) && (d_cnt_q == DC_W'(D_NIBS));
  end

  // MAC datapath. The step counter {v,e} equals the data byte index 4v+e.
  always_comb begin
    w_byte_s   = w_q[{step_q[1:0], 3'b000} +: 8];
    d_byte_s   = d_q[{step_q, 3'b000} +: 8];
    prod_s     = $signed(w_byte_s) * $signed(d_byte_s);
    prod_ext_s = {{(ACC_W-16){prod_s[15]}}, prod_s};
    if (step_q[1:0] == 2'b00) begin
      acc_d = prod_ext_s;
    end else begin
      acc_d = acc_q + prod_ext_s;
    end
  end

  // ReLU clip plus saturation of the completed accumulator to one byte.
  always_comb begin
    if (acc_q[ACC_W-1]) begin
      relu_s = 8'h00;
    end else if (|acc_q[ACC_W-2:8]) begin
      relu_s = 8'hFF;
    end else begin
      relu_s = acc_q[7:0];
    end
  end

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      d_q         <= '0;
      w_cnt_q     <= '0;
      d_cnt_q     <= '0;
      acc_q       <= '0;
      step_q      <= 4'd0;
      pend_q      <= 1'b0;
      out_byte_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (cmd_clear_s) begin
      // CLEAR aborts any pass silently. The last out_byte value is kept.
      state_q     <= S_IDLE;
      w_q         <= '0;
      d_q         <= '0;
      w_cnt_q     <= '0;
      d_cnt_q     <= '0;
      acc_q       <= '0;
      step_q      <= 4'd0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= pend_q;
      if (pend_q) begin
        out_byte_q <= relu_s;
      end
      pend_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_w_s) begin
            w_q <= {w_q[WEIGHT_W-5:0], nib_i};
            if (w_cnt_q != WC_W'(W_NIBS)) begin
              w_cnt_q <= w_cnt_q + WC_W'(1);
            end
          end else if (load_d_s) begin
            d_q <= {d_q[DATA_W-5:0], nib_i};
            if (d_cnt_q != DC_W'(D_NIBS)) begin
              d_cnt_q <= d_cnt_q + DC_W'(1);
            end
          end else if (cmd_start_s) begin
            if (full_s) begin
              state_q <= S_MAC;
              busy_q  <= 1'b1;
              step_q  <= 4'd0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_MAC: begin
          if (load_w_s || load_d_s || cmd_start_s) begin
            err_q <= 1'b1;
          end
          acc_q  <= acc_d;
          step_q <= step_q + 4'd1;
          if (step_q[1:0] == 2'b11) begin
            pend_q <= 1'b1;
          end
          if (step_q == 4'd15) begin
            state_q <= S_LAST;
          end
        end
        S_LAST: begin
          if (load_w_s || load_d_s || cmd_start_s) begin
            err_q <= 1'b1;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_byte_o  = out_byte_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_nibble_mac_sequencer.sv
// Self-checking bench for nibble_mac_sequencer. The bench drives inputs on the
// falling edge and samples outputs on the following falling edge. Each table
// row is one load plus START pass with hand-computed result bytes.
module tb_nibble_mac_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] nib;
  logic [1:0] sel;
  logic       strobe;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       err;

  int total;
  int bad;

  nibble_mac_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nib_i       (nib),
    .sel_i       (sel),
    .strobe_i    (strobe),
    .out_byte_o  (out_byte),
    .out_valid_o (out_valid),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row layout: exp holds the vector-v result byte at bits [8v+7:8v].
  typedef struct {
    logic [31:0]  w;
    logic [127:0] d;
    logic [31:0]  exp;
  } vec_t;

  localparam logic [127:0] D_SEQ = 128'h100F0E0D0C0B0A090807060504030201;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // The caller is at a falling edge. The strobe is sampled at the next rising edge.
  task automatic strobe_one(input logic [1:0] s, input logic [3:0] n);
    strobe = 1'b1;
    sel    = s;
    nib    = n;
    @(negedge clk);
    strobe = 1'b0;
    sel    = 2'b00;
    nib    = 4'h0;
  endtask

  task automatic load_w(input logic [31:0] w, input int count);
    for (int i = 7; i > 7 - count; i--) strobe_one(2'b01, w[4*i +: 4]);
  endtask

  task automatic load_d(input logic [127:0] d);
    for (int i = 31; i >= 0; i--) strobe_one(2'b10, d[4*i +: 4]);
  endtask

  task automatic clear_cmd();
    strobe_one(2'b11, 4'b0010);
  endtask

  // START, then observe cycles T+1..T+18. An optional strobe is driven so
  // that the rising edge T+inj_n+1 samples it. Use inj_n = -1 for no strobe.
  // A CLEAR strobe cuts off all later activity.
  task automatic run_pass(input logic [31:0] exp, input int inj_n,
                          input logic [1:0] inj_sel, input logic [3:0] inj_nib,
                          input logic exp_err);
    int  cut;
    logic ev;
    cut = (inj_n >= 0 && inj_sel == 2'b11 && inj_nib == 4'b0010) ? inj_n : 99;
    strobe_one(2'b11, 4'b0001);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int n = 1; n <= 18; n++) begin
      if (n - 1 == inj_n) begin
        strobe = 1'b1; sel = inj_sel; nib = inj_nib;
      end else begin
        strobe = 1'b0; sel = 2'b00; nib = 4'h0;
      end
      @(negedge clk);
      ev = (n == 5 || n == 9 || n == 13 || n == 17) && (n <= cut);
      chk($sformatf("out_valid_T+%0d", n), {31'd0, out_valid}, {31'd0, ev});
      if (ev) chk($sformatf("out_byte_T+%0d", n), {24'd0, out_byte}, {24'd0, exp[8*((n-5)/4) +: 8]});
      chk($sformatf("done_T+%0d", n), {31'd0, done}, {31'd0, (n == 17 && n <= cut)});
      chk($sformatf("busy_T+%0d", n), {31'd0, busy}, {31'd0, (n <= 16 && n <= cut)});
    end
    strobe = 1'b0; sel = 2'b00; nib = 4'h0;
    chk("err_end_of_pass", {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    int pulses;
    total = 0;
    bad = 0;
    rst_n = 1'b0; strobe = 1'b0; sel = 2'b00; nib = 4'h0;

    vecs[0] = '{32'h01010101, D_SEQ, 32'h3A2A1A0A};           // 58,42,26,10
    vecs[1] = '{32'hFFFFFFFF, D_SEQ, 32'h00000000};           // all negative
    vecs[2] = '{32'h7F7F7F7F, {16{8'h7F}}, 32'hFFFFFFFF};     // 64516 each
    vecs[3] = '{32'h02FF0301, D_SEQ, 32'h4834200C};           // 72,52,32,12
    vecs[4] = '{32'h80808080, {16{8'h80}}, 32'hFFFFFFFF};     // +65536
    vecs[5] = '{32'h80808080, {16{8'h7F}}, 32'h00000000};     // -65024
    vecs[6] = '{32'h01010101, 128'h807F0101_4040403F_40404040_FFFFFFFF,
                32'h01FFFF00};                                // 1,255,256->255,-4

    repeat (2) @(negedge clk);
    chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven passes.
    for (int i = 0; i < 7; i++) begin
      clear_cmd();
      load_w(vecs[i].w, 8);
      load_d(vecs[i].d);
      run_pass(vecs[i].exp, -1, 2'b00, 4'h0, 1'b0);
    end
    // The registers are retained, so a repeated START gives the same results.
    run_pass(vecs[6].exp, -1, 2'b00, 4'h0, 1'b0);

    // START with only 7 weight nibbles loaded.
    clear_cmd();
    load_w(vecs[0].w, 7);
    load_d(D_SEQ);
    strobe_one(2'b11, 4'b0001);
    chk("short_load_err", {31'd0, err}, 32'd1);
    chk("short_load_busy", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid || busy) pulses++;
    end
    chk("short_load_no_activity", pulses, 32'd0);
    clear_cmd();
    chk("clear_resets_err", {31'd0, err}, 32'd0);
    strobe_one(2'b11, 4'b0001);   // counters are now 0, so START is rejected
    chk("clear_resets_counters", {31'd0, err}, 32'd1);

    // An unknown command code is ignored.
    clear_cmd();
    load_w(vecs[0].w, 8);
    load_d(D_SEQ);
    strobe_one(2'b11, 4'b0100);
    chk("unknown_cmd_err", {31'd0, err}, 32'd0);
    chk("unknown_cmd_busy", {31'd0, busy}, 32'd0);

    // CLEAR at step k=6 (edge T+7): only v0 is emitted and done never pulses.
    run_pass(vecs[0].exp, 6, 2'b11, 4'b0010, 1'b0);
    load_w(vecs[0].w, 8);
    load_d(D_SEQ);
    run_pass(vecs[0].exp, -1, 2'b00, 4'h0, 1'b0);

    // A weight nibble during busy sets err; the results stay the same.
    run_pass(vecs[0].exp, 2, 2'b01, 4'hA, 1'b1);
    run_pass(vecs[0].exp, -1, 2'b00, 4'h0, 1'b1);  // weights still intact

    // Reset mid-pass clears every output at once.
    clear_cmd();
    load_w(vecs[0].w, 8);
    load_d(D_SEQ);
    strobe_one(2'b11, 4'b0001);
    repeat (8) @(negedge clk);
    chk("midpass_v0_byte", {24'd0, out_byte}, 32'd10);
    chk("midpass_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_mac_sequencer.md
Name: nibble_mac_sequencer

Overview:
- Sequences one inference pass for the nibble-loaded weight/data datapath.
- Accepts 4-bit load nibbles into a 32-bit weight register (4 signed int8 weights) and a 128-bit data register (4 vectors × 4 signed int8).
- On command, runs a single shared 8×8 MAC over 16 steps.
- Emits 4 ReLU-clipped result bytes with a valid strobe; reports busy, done and err status.

Parameters:
- WEIGHT_W, 32, weight register width (4 × int8)
- DATA_W, 128, data register width (16 × int8, 4 vectors)
- ACC_W, 18, signed accumulator width (covers ±65536)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, active-low, asynchronous
- nib  in  4  load nibble, or command code when sel=11
- sel  in  2  00 none, 01 weight nibble, 10 data nibble, 11 command
- strobe  in  1  qualifies nib/sel for exactly this cycle
- out_byte  out  8  result byte
- out_valid  out  1  one-cycle pulse, out_byte valid
- busy  out  1  high while computing
- done  out  1  one-cycle pulse at end of pass
- err  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0): both registers, fill counters, accumulator and step counter = 0; state IDLE; out_byte=0, out_valid=0, busy=0, done=0, err=0.
- Weight load (strobe, sel=01, IDLE): w <= {w[27:0], nib}. The fill counter increments and saturates at 8.
- Data load (strobe, sel=10, IDLE): d <= {d[123:0], nib}. The fill counter saturates at 32.
- Loading is MSB-first, so the last nibble is bits [3:0].
- Loads continue shifting after saturation; the register always holds the most recent nibbles.
- Byte indexing: weight e = w[8e+7:8e]; data byte j = d[8j+7:8j]; vector v uses data bytes 4v..4v+3.
- Commands (strobe, sel=11):
  - nib=0001 is START.
  - nib=0010 is CLEAR. Valid in any state: zeros registers, counters, acc and err; aborts computation to IDLE with no done and no out_valid.
  - Any other code is ignored.
- START in IDLE with both counters full: state MAC, busy=1 from the next cycle.
- START in IDLE with either counter not full: err<=1, stay IDLE.
- Any load or START strobe while busy: ignored, err<=1.
- MAC state runs 16 cycles with step k=0..15, v=k[3:2], e=k[1:0]:
  - e=0: acc <= prod; otherwise acc <= acc + prod.
  - prod = signed(w byte e) × signed(d byte 4v+e), sign-extended to ACC_W.
- Result emission: the cycle after each e=3 step, out_byte = 0 if acc<0; 255 if acc>255; else acc[7:0]. out_valid=1 for that single cycle.
- Output ordering: v0, v1, v2, v3 results come out in that order.
- out_byte holds its last value between pulses.
- Timing for START accepted at edge T:
  - MAC steps occupy cycles T+1..T+16.
  - out_valid at T+5, T+9, T+13, T+17.
  - done pulses at T+17, concurrent with the last out_valid.
  - busy falls at T+17; state returns to IDLE at T+18.
- Registers and fill counters are retained after a pass, so a repeated START reproduces identical results.
- CLEAR and START in the same strobe are impossible because they are distinct codes.
- Reset mid-pass aborts immediately; all outputs return to reset values.

Test Plan:
- Load w=0x01010101, d=0x100F0E0D0C0B0A090807060504030201, START -> out_byte 10, 26, 42, 58 at T+5/9/13/17; done at T+17; err=0.
- Load w=0xFFFFFFFF (all −1), same data, START -> four out_valid pulses, each out_byte=0 (ReLU).
- Load w=0x7F7F7F7F, d all 0x7F, START -> acc=64516 per vector; four bytes of 255 (saturation).
- Load 7 weight nibbles + 32 data nibbles, START -> err=1, busy stays 0, no out_valid. Then CLEAR -> err=0, counters 0.
- Valid load, START, CLEAR at step k=6 -> busy drops next cycle; only the v0 result emitted; no done. Reload and START gives correct results.
- Weight nibble strobe during busy -> err=1, weights unchanged, results identical to an undisturbed run. Separately, rst_n low mid-pass -> all outputs 0 immediately.
